pipe_adder: RTL

- Parametrised, pipelined successor to the single-bit half adder: adds two WIDTH-bit operands plus carry-in and produces a WIDTH-bit sum and carry-out.
- The add is split into STAGES equal slices. Each slice's carry is registered into the next stage, which gives a high-fmax ripple pipeline.
- Valid/ready handshake on both sides, so it drops into streaming datapaths (accumulators, checksum units).

---
 rtl/adder_pkg.sv | 8 +
 rtl/adder_slice.sv | 12 +
 rtl/pipe_adder.sv | 90 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and slice-width helper for the pipelined adder
package adder_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit full adder, one per pipeline stage
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + (W+1)'(c_i);
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: elastic STAGES-deep ripple-carry pipeline computing a + b + cin.
// Define PIPE_ADDER_OVF_EN to add the signed overflow output.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PIPE_ADDER_OVF_EN
  ,output logic            overflow
`endif
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;
  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  stage_t            src  [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] co_w;
  logic [CHUNK-1:0]  s_w  [STAGES];
  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end
  // A stage may advance unless it and every stage after it are full while the output stalls.
  always_comb begin
    logic full;
    full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full & st_q[k].v;
      adv[k] = out_ready | ~full;
    end
  end
  always_comb begin
    src[0] = '{v: in_valid, c: cin, a: a, b: b, s: '0};
    for (int k = 1; k < STAGES; k++) src[k] = st_q[k-1];
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_st
    adder_slice #(.W(CHUNK)) u_slice (
      .a_i(src[i].a[i*CHUNK +: CHUNK]),
      .b_i(src[i].b[i*CHUNK +: CHUNK]),
      .c_i(src[i].c),
      .s_o(s_w[i]),
      .c_o(co_w[i])
    );
  end
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k]                     = src[k];
      st_d[k].c                   = co_w[k];
      st_d[k].s[k*CHUNK +: CHUNK] = s_w[k];
    end
  end
  // Bubbles only clear the valid bit so payload registers stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k] && src[k].v) st_q[k] <= st_d[k];
        else if (adv[k]) st_q[k].v <= 1'b0;
      end
    end
  end
  assign in_ready  = adv[0];
  assign out_valid = st_q[STAGES-1].v;
  assign sum       = st_q[STAGES-1].s;
  assign carry     = st_q[STAGES-1].c;
`ifdef PIPE_ADDER_OVF_EN
  // Carry into the MSB is recovered as a ^ b ^ s at that bit.
  assign overflow  = st_q[STAGES-1].a[WIDTH-1] ^ st_q[STAGES-1].b[WIDTH-1] ^
                     st_q[STAGES-1].s[WIDTH-1] ^ st_q[STAGES-1].c;
`endif
endmodule
